cmd_scheduler: RTL
==================

CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter TMO_CYCLES, default 1_000_000: clocks allowed from launch to response before timeout.
REQ-003 SHALL have ports: clk  input  1  system clock.
REQ-004 SHALL have ports: rst  input  1  reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: push  input  1  enqueue push_cmd this cycle.
REQ-006 SHALL have ports: push_cmd  input  16  command to enqueue.
REQ-007 SHALL have ports: full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have ports: count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-009 SHALL have ports: ovfl  output  1  one-cycle pulse, push dropped while full.
REQ-010 SHALL have ports: snd_cmd  output  1  launch strobe to the remote comm transmitter.
REQ-011 SHALL have ports: cmd  output  16  command in flight, stable from launch until return to IDLE.
REQ-012 SHALL have ports: cmd_sent  input  1  transmitter finished both bytes.
REQ-013 SHALL have ports: resp_rdy  input  1  response byte received.
REQ-014 SHALL have ports: resp  input  8  response byte.
REQ-015 SHALL have ports: busy  output  1  state is not IDLE.
REQ-016 SHALL have ports: done  output  1  one-cycle pulse, command completed with a response.
REQ-017 SHALL have ports: done_resp  output  8  last captured response, held until next done.
REQ-018 SHALL have ports: tmo_err  output  1  one-cycle pulse, command abandoned on timeout.

Function
REQ-019 FIFO SHALL accept push iff !full; push while full SHALL be dropped and pulse ovfl the next cycle.
REQ-020 Simultaneous accepted push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 FSM states SHALL be IDLE, LAUNCH, WAIT_SENT, WAIT_RESP.
REQ-022 IDLE with count>0 SHALL pop head into cmd register and go to LAUNCH; empty IDLE SHALL hold.
REQ-023 snd_cmd SHALL be registered and high exactly one cycle, in LAUNCH; LAUNCH SHALL go to WAIT_SENT unconditionally.
REQ-024 Push into empty FIFO in IDLE at edge N SHALL produce snd_cmd high in cycle N+2.
REQ-025 WAIT_SENT SHALL go to WAIT_RESP on cmd_sent.
REQ-026 WAIT_RESP SHALL on resp_rdy capture resp into done_resp, pulse done next cycle, return to IDLE.
REQ-027 resp_rdy and cmd_sent SHALL be ignored in states where they are not awaited.
REQ-028 Timeout counter SHALL clear in LAUNCH, increment each cycle in WAIT_SENT/WAIT_RESP, saturate, and fire when it reaches TMO_CYCLES-1.
REQ-029 resp_rdy in the same cycle as timeout firing SHALL win (done, no tmo_err).
REQ-030 Back-to-back: IDLE SHALL pop the next command the cycle after return, giving one IDLE cycle between commands.

Reset
REQ-031 rst SHALL empty FIFO, state=IDLE, clear timer and retry count; outputs: full=0, count=0, ovfl=0, snd_cmd=0, cmd=0, busy=0, done=0, done_resp=0, tmo_err=0.
REQ-032 rst mid-command SHALL abandon it without done or tmo_err pulse; rst has priority over push.

Configuration
REQ-033 Macro CMD_SCHED_RETRY_EN SHALL compile in retry logic.
REQ-034 With CMD_SCHED_RETRY_EN: on timeout with retry count <2, SHALL increment retry count and go to LAUNCH re-sending the same cmd; third timeout SHALL pulse tmo_err and go to IDLE; retry count clears on pop.
REQ-035 Without CMD_SCHED_RETRY_EN: first timeout SHALL pulse tmo_err and return to IDLE; no retry register exists.

Verification (TMO_CYCLES=64, DEPTH=4)
REQ-036 Push 16'h1234 into empty FIFO; cmd_sent 20 cycles after snd_cmd, resp_rdy with 8'hA5 5 cycles later -> snd_cmd at N+2, cmd=16'h1234, done pulse, done_resp=8'hA5.
REQ-037 Push 16'hFFFF,16'h0000,16'h8BA2,16'h1111,16'h2222 on consecutive cycles while stalled -> last push dropped with ovfl pulse, full=1, four commands issued in order.
REQ-038 Never return resp_rdy -> without macro one tmo_err 64 cycles after launch; with macro three snd_cmd pulses of same cmd, then one tmo_err.
REQ-039 resp_rdy asserted in the timeout-firing cycle -> done pulse, no tmo_err, no retry.
REQ-040 Assert rst during WAIT_RESP -> next cycle busy=0, count=0, no done/tmo_err; stray resp_rdy in IDLE ignored.

Source files
------------

// File: rtl/cmd_scheduler.sv
// rtl/cmd_scheduler.sv - command FIFO feeding a launch/wait-sent/wait-response scheduler
//
// Purpose:
//   Buffers 16-bit commands in a DEPTH-entry FIFO and issues them one at a
//   time to a remote comm transmitter. The scheduler launches a command,
//   waits for the transmitter to report both bytes sent, then waits for a
//   response byte. Each command gets TMO_CYCLES clocks from launch before it
//   is abandoned with a tmo_err pulse.
//
// Optional feature:
//   `define CMD_SCHED_RETRY_EN  - on timeout, re-launch the same command up to
//                                 two more times before reporting tmo_err.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   push       in   enqueue push_cmd this cycle
//   push_cmd   in   [15:0] command to enqueue
//   full       out  FIFO holds DEPTH entries
//   count      out  [$clog2(DEPTH):0] FIFO occupancy
//   ovfl       out  one-cycle pulse, push dropped while full
//   snd_cmd    out  launch strobe to the transmitter
//   cmd        out  [15:0] command in flight
//   cmd_sent   in   transmitter finished both bytes
//   resp_rdy   in   response byte received
//   resp       in   [7:0] response byte
//   busy       out  scheduler not idle
//   done       out  one-cycle pulse, command completed with a response
//   done_resp  out  [7:0] last captured response
//   tmo_err    out  one-cycle pulse, command abandoned on timeout

module cmd_scheduler #(
  parameter int DEPTH      = 4,
  parameter int TMO_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [15:0]              push_cmd,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovfl,
  output logic                     snd_cmd,
  output logic [15:0]              cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               done_resp,
  output logic                     tmo_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_SENT = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [TW-1:0]     tmr;
  logic              do_push, do_pop;
  logic              resp_cap, tmo_path, tmo_fire, tmo_hit;
`ifdef CMD_SCHED_RETRY_EN
  logic [1:0]        retry_cnt;
  logic              retry;
`endif

  assign full    = (count == DEPTH_C);
  assign busy    = (state != IDLE);
  assign do_push = push & ~full;
  // The timer counts up to TMO_LAST on the edge that ends the firing cycle,
  // so firing is decided one count early; >= keeps it firing once saturated.
  assign tmo_hit = (tmr >= TMO_LAST - TW'(1));

  always_comb begin
    state_nxt = state;
    do_pop    = 1'b0;
    resp_cap  = 1'b0;
    tmo_path  = 1'b0;
    tmo_fire  = 1'b0;
`ifdef CMD_SCHED_RETRY_EN
    retry     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (count != '0) begin
          do_pop    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT_SENT;
      WAIT_SENT: begin
        if (tmo_hit)       tmo_path  = 1'b1;
        else if (cmd_sent) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A response arriving in the firing cycle still completes the command.
        if (resp_rdy) begin
          resp_cap  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          tmo_path = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tmo_path) begin
`ifdef CMD_SCHED_RETRY_EN
      if (retry_cnt < 2'd2) begin
        retry     = 1'b1;
        state_nxt = LAUNCH;
      end else begin
        tmo_fire  = 1'b1;
        state_nxt = IDLE;
      end
`else
      tmo_fire  = 1'b1;
      state_nxt = IDLE;
`endif
    end
  end

  // FIFO storage has no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovfl      <= 1'b0;
      snd_cmd   <= 1'b0;
      cmd       <= '0;
      done      <= 1'b0;
      done_resp <= '0;
      tmo_err   <= 1'b0;
      tmr       <= '0;
`ifdef CMD_SCHED_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      ovfl    <= push & full;
      snd_cmd <= (state_nxt == LAUNCH);
      done    <= resp_cap;
      tmo_err <= tmo_fire;

      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        cmd    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase

      if (resp_cap) done_resp <= resp;

      if (state == LAUNCH)
        tmr <= '0;
      else if ((state == WAIT_SENT || state == WAIT_RESP) && tmr != TMO_LAST)
        tmr <= tmr + TW'(1);

`ifdef CMD_SCHED_RETRY_EN
      if (do_pop)     retry_cnt <= '0;
      else if (retry) retry_cnt <= retry_cnt + 2'd1;
`endif
    end
  end

endmodule
